// File: rtl/kb_pkg.sv
// kb_pkg: shared state encoding and PS/2 frame constants for the keyboard front end.
package kb_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam logic KB_START_BIT = 1'b0;
    localparam logic KB_STOP_BIT = 1'b1;
    localparam logic [7:0] KB_BREAK_CODE = 8'hF0;
    localparam int KB_FRAME_DATA_BITS = 8;
endpackage

// File: rtl/kb_sync_filter.sv
// kb_sync_filter: synchronises the PS/2 lines, deglitches clk_kb and pulses fall on a filtered 1->0.
module kb_sync_filter
    import kb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clk_kb,
    input  logic data_kb,
    output logic data_s,
    output logic fall
);
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic [FILTER_LEN-1:0] hist;
    logic level;

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            clk_sync <= '1;
            data_sync <= '1;
            hist <= '1;
            level <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_kb};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_kb};
            hist <= (hist << 1) | FILTER_LEN'(clk_sync[SYNC_STAGES-1]);
            level <= &hist ? 1'b1 : ~|hist ? 1'b0 : level;
        end

    // level drops on the next edge, so this is high for exactly one cycle
    assign fall = level & ~|hist;
    assign data_s = data_sync[SYNC_STAGES-1];
endmodule

// File: rtl/kb_scan_fifo.sv
// kb_scan_fifo: PS/2 receiver with frame checking and timeout feeding a show-ahead scan-code FIFO.
// Define KB_BREAK_MERGE_EN to fold the F0 break prefix into bit 8 of the following code.
module kb_scan_fifo
    import kb_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clk_kb,
    input  logic data_kb,
    input  logic rd_en,
    input  logic clr_err,
    output logic [OUT_W-1:0] key_out,
    output logic key_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic overflow,
    output logic frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef KB_BREAK_MERGE_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic data_s, fall, timeout, good, frame_ok, push, err_ev, pop, wr, ovf_ev, full;
    state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic par, par_n;
    logic [TW-1:0] tmo;
    logic [EW-1:0] push_data;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
`ifdef KB_BREAK_MERGE_EN
    logic brk, brk_n, is_brk;
`endif

    kb_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync (
        .Clk(Clk), .Rst(Rst), .clk_kb(clk_kb), .data_kb(data_kb), .data_s(data_s), .fall(fall)
    );

    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        shreg_n = shreg;
        par_n = par;
        frame_ok = 1'b0;
        err_ev = 1'b0;
        timeout = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES);
        good = data_s == KB_STOP_BIT && ^{shreg, par};
        if (timeout) begin
            state_n = IDLE;
            err_ev = 1'b1;
        end else if (fall)
            case (state)
                IDLE: begin
                    state_n = data_s == KB_START_BIT ? DATA : IDLE;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    shreg_n = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n = bit_cnt == 3'(KB_FRAME_DATA_BITS - 1) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n = data_s;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    frame_ok = good;
                    err_ev = !good;
                end
            endcase
`ifdef KB_BREAK_MERGE_EN
        // a second consecutive F0 is data, not another prefix
        is_brk = frame_ok && !brk && shreg == KB_BREAK_CODE;
        brk_n = err_ev ? 1'b0 : frame_ok ? is_brk : brk;
        push = frame_ok && !is_brk;
        push_data = {brk, shreg};
`else
        push = frame_ok;
        push_data = shreg;
`endif
    end

    assign key_valid = count != '0;
    assign full = count == CW'(FIFO_DEPTH);
    assign pop = rd_en && key_valid;
    assign wr = push && (!full || pop);
    assign ovf_ev = push && full && !pop;
    assign key_out = key_valid ? OUT_W'(mem[rd_ptr]) : '0;

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            tmo <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            frame_err <= 1'b0;
`ifdef KB_BREAK_MERGE_EN
            brk <= 1'b0;
`endif
        end else begin
            state <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg <= shreg_n;
            par <= par_n;
            tmo <= (state == IDLE || fall || timeout) ? '0 : tmo + TW'(1);
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(wr) - CW'(pop);
            overflow <= ovf_ev | (overflow & ~clr_err);
            frame_err <= err_ev | (frame_err & ~clr_err);
`ifdef KB_BREAK_MERGE_EN
            brk <= brk_n;
`endif
        end

    always_ff @(posedge Clk)
        if (wr) mem[wr_ptr] <= push_data;
endmodule

// File: doc/kb_scan_fifo.md
Name: kb_scan_fifo

Overview:
Parametrised successor to the single-register keyboard front end feeding the CPU load mux.
- Receives PS/2 device-to-host frames on clk_kb/data_kb, checks start, parity and stop bits, and applies a frame timeout.
- Queues scan codes in a show-ahead FIFO.
- Presents the FIFO head zero-extended to CPU width, with a read handshake so no keystroke is lost between CPU polls.

Parameters:
OUT_W, 16, width of key_out; must be ≥ 9 when BREAK_MERGE_EN is defined.
FIFO_DEPTH, 8, entry count; power of two, ≥ 2.
SYNC_STAGES, 2, flops in the synchroniser for clk_kb and for data_kb; ≥ 2.
FILTER_LEN, 4, consecutive equal synchronised clk_kb samples needed to change the filtered level.
TIMEOUT_CYCLES, 50000, Clk cycles allowed without a falling edge while mid-frame before the frame is abandoned.

Ports:
Clk  in  1  system clock; all state on rising edge.
Rst  in  1  asynchronous, active-low reset.
clk_kb  in  1  PS/2 clock, asynchronous to Clk.
data_kb  in  1  PS/2 data, asynchronous to Clk.
rd_en  in  1  pop the FIFO head this cycle.
clr_err  in  1  clear the sticky error flags.
key_out  out  OUT_W  FIFO head, zero-extended; 0 when empty.
key_valid  out  1  FIFO not empty.
count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
overflow  out  1  sticky; a byte was dropped because the FIFO was full.
frame_err  out  1  sticky; parity, stop or timeout failure.

Behaviour:
- Reset (Rst=0, async): FSM=IDLE; FIFO empty; key_out=0, key_valid=0, count=0, overflow=0, frame_err=0; filtered clock level=1.
- Input path: both inputs pass SYNC_STAGES flops. Filtered clk_kb changes level only after FILTER_LEN identical samples. A fall event is a 1-cycle pulse on a filtered 1→0 transition. Data is sampled from the synchronised data_kb in the fall cycle.
- FSM advances on fall events only:
  - IDLE: bit 0 → DATA with bit counter 0; bit 1 → stay in IDLE (no error).
  - DATA: shift bits LSB-first into an 8-bit register. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: the frame is good when stop=1 and (8 data bits + parity) has an odd number of ones. Good frame: push request in the same cycle. Bad frame: frame_err is set and nothing is pushed. Either way → IDLE.
- Timeout: in any state other than IDLE, a counter increments each Clk and clears on each fall event. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, the partial frame is discarded and frame_err is set.
- FIFO timing:
  - The push is written at the Clk edge ending the STOP fall cycle.
  - key_valid and key_out update on that same edge, so data is visible the cycle after the stop-bit sample.
- Reads:
  - rd_en with key_valid=1 advances the head at the edge.
  - rd_en with key_valid=0 is ignored; no underflow state exists.
- Full FIFO:
  - Push without pop: the byte is dropped and overflow is set.
  - Push and pop in the same cycle: both take effect and count is unchanged. This applies when full and at every other occupancy.
  - Push and pop on an empty FIFO: only the push takes effect.
- Pointers: $clog2(FIFO_DEPTH) bits each, wrap naturally. count is maintained separately.
- Sticky flags: clr_err clears overflow and frame_err at the edge. If a new error event occurs in the same cycle as clr_err, the set wins.
- Reset mid-frame discards the partial frame and all FIFO contents.

Optional Feature:
KB_BREAK_MERGE_EN:
- Defined:
  - A good frame carrying 8'hF0 is not pushed; instead a break_pending flag is set.
  - The next good byte is pushed with bit 8 = 1, and the flag is cleared.
  - A frame error or timeout also clears the flag.
  - F0 F0 pushes 9'h1F0.
- Not defined: every good byte is pushed raw; bit 8 is always 0.

Decomposition:
- Package kb_pkg:
  - state enum (IDLE, DATA, PARITY, STOP);
  - constants KB_START_BIT=0, KB_STOP_BIT=1, KB_BREAK_CODE=8'hF0, KB_FRAME_DATA_BITS=8.
- Sub-module kb_sync_filter: synchroniser, glitch filter and fall-event pulse, parametrised by SYNC_STAGES and FILTER_LEN.
- The FSM and FIFO stay in kb_scan_fifo.

Test Plan:
- Single frame 0x1C:
  - Stimulus: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1.
  - Required: key_valid=1 and key_out=16'h001C one cycle after the stop fall; count=1. rd_en for 1 cycle → key_valid=0, key_out=0.
- Parity error: same frame with parity 1 → no push, frame_err=1, count=0. clr_err → frame_err=0.
- Overflow: 9 good frames 0x01..0x09 with FIFO_DEPTH=8 and no reads → count=8, overflow=1. Pops return 0x01..0x08 in order.
- Simultaneous events: FIFO full, rd_en asserted in the push cycle of 0x0A → count stays 8, overflow stays 0, the last entry read is 0x0A.
- Timeout and glitch rejection:
  - Stop after 4 data bits and wait TIMEOUT_CYCLES → frame_err=1, FSM back in IDLE. A following good frame 0x2D is accepted.
  - A 2-cycle low glitch on clk_kb (with FILTER_LEN=4) produces no fall event.
- Break merge (KB_BREAK_MERGE_EN): frames F0 then 1C → exactly one entry, key_out=16'h011C. Without the macro → two entries, 0x00F0 then 0x001C.
